// File: rtl/mram_pkg.sv
// mram_pkg: shared types, default widths and strobe encodings for mram_ctrl.
package mram_pkg;
  localparam int MRAM_ADDR_W = 20;
  localparam int MRAM_DATA_W = 16;
  localparam int MRAM_LEN_W = 4;
  typedef logic [1:0] be_t;
  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_STROBE, RD_STROBE, GAP} state_t;
  // Strobe bundle {e, g, w, lb, ub}, all active low
  typedef logic [4:0] strb_t;
  localparam strb_t STRB_OFF = 5'b11111;
  function automatic strb_t strb_wr(input be_t be);
    return {3'b010, ~be[0], ~be[1]};
  endfunction
  function automatic strb_t strb_rd(input be_t be);
    return {3'b001, ~be[0], ~be[1]};
  endfunction
endpackage

// File: rtl/mram_ctrl_if.sv
// mram_ctrl_if: command, write-data and read-return handshakes of mram_ctrl.
interface mram_ctrl_if import mram_pkg::*; #(
  parameter int ADDR_W = MRAM_ADDR_W,
  parameter int DATA_W = MRAM_DATA_W,
  parameter int LEN_W = MRAM_LEN_W
);
  logic cmd_valid, cmd_ready, cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  be_t cmd_be;
  logic wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic rd_valid, rd_last, busy;
  logic [DATA_W-1:0] rd_data;
  modport master (output cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_be, wr_valid, wr_data,
                  input cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy);
  modport slave (input cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_be, wr_valid, wr_data,
                 output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy);
endinterface

// File: rtl/mram_beat_timer.sv
// mram_beat_timer: loadable down-counter; done is high once the count reaches zero.
module mram_beat_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? val : cnt - W'(cnt != '0);
  assign done = cnt == '0;
endmodule

// File: rtl/mram_ctrl.sv
// mram_ctrl: valid/ready command stream to timed MRAM strobe sequences.
// Define MRAM_CTRL_BURST_EN to honour cmd_len (multi-beat bursts); otherwise every command is one beat.
module mram_ctrl import mram_pkg::*; #(
  parameter int ADDR_W = MRAM_ADDR_W,
  parameter int DATA_W = MRAM_DATA_W,
  parameter int LEN_W = MRAM_LEN_W,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mram_ctrl_if.slave        bus,
  output logic              e_chipEnable_n,
  output logic              g_outputEnable_n,
  output logic              w_writeEnable_n,
  output logic              lb_lowerByteEnable_n,
  output logic              ub_upperByteEnable_n,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dqi_datainput,
  input  logic [DATA_W-1:0] dqo_dataoutput
);
  localparam int TW = 8;
  state_t state;
  strb_t strb;
  be_t be, be_eff;
  logic we, last, accept, rd_go, wr_go, gap_go, tload, tdone;
  logic [TW-1:0] tval;
  assign {e_chipEnable_n, g_outputEnable_n, w_writeEnable_n,
          lb_lowerByteEnable_n, ub_upperByteEnable_n} = strb;
  assign accept = bus.cmd_ready & bus.cmd_valid;
  assign be_eff = bus.cmd_be == '0 ? 2'b11 : bus.cmd_be;
  assign rd_go = (accept & ~bus.cmd_we) | (state == GAP & tdone & ~last & ~we);
  assign wr_go = state == WR_WAIT & bus.wr_valid;
  assign gap_go = (state == WR_STROBE | state == RD_STROBE) & tdone;
  assign tload = rd_go | wr_go | gap_go;
  assign tval = rd_go ? TW'(RD_CYCLES - 1) : wr_go ? TW'(WR_CYCLES - 1) : TW'(GAP_CYCLES - 1);
  mram_beat_timer #(.W(TW)) u_timer (.clk, .rst_n, .load(tload), .val(tval), .done(tdone));
`ifdef MRAM_CTRL_BURST_EN
  logic [LEN_W-1:0] left;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) left <= '0;
    else if (accept) left <= bus.cmd_len;
    else if (state == GAP && tdone && !last) left <= left - 1'b1;
  assign last = left == '0;
`else
  assign last = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      we <= 1'b0;
      be <= '0;
      strb <= STRB_OFF;
      address <= '0;
      dqi_datainput <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_last <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.wr_ready <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            we <= bus.cmd_we;
            be <= be_eff;
            address <= bus.cmd_addr;
            bus.cmd_ready <= 1'b0;
            bus.busy <= 1'b1;
            bus.wr_ready <= bus.cmd_we;
            state <= bus.cmd_we ? WR_WAIT : RD_STROBE;
            strb <= bus.cmd_we ? STRB_OFF : strb_rd(be_eff);
          end else bus.cmd_ready <= 1'b1;
        WR_WAIT:
          if (bus.wr_valid) begin
            dqi_datainput <= bus.wr_data;
            bus.wr_ready <= 1'b0;
            strb <= strb_wr(be);
            state <= WR_STROBE;
          end
        WR_STROBE:
          if (tdone) begin
            strb <= STRB_OFF;
            state <= GAP;
          end
        RD_STROBE:
          if (tdone) begin
            bus.rd_data <= dqo_dataoutput;
            bus.rd_valid <= 1'b1;
            bus.rd_last <= last;
            strb <= STRB_OFF;
            state <= GAP;
          end
        GAP:
          if (tdone && last) begin
            bus.cmd_ready <= 1'b1;
            bus.busy <= 1'b0;
            state <= IDLE;
          end else if (tdone) begin
            address <= address + 1'b1;
            bus.wr_ready <= we;
            strb <= we ? STRB_OFF : strb_rd(be);
            state <= we ? WR_WAIT : RD_STROBE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/mram_ctrl.md
# mram_ctrl

Synchronous initiator for the 16-bit MRAM parallel interface. It turns a valid/ready command stream into correctly timed chip-, output-, write- and byte-enable strobe sequences, and supports multi-beat bursts with incrementing addresses. It sits between the FPGA-side serial/parallel conversion logic and the `MRAM_model` pins, driving the MRAM in place of the hand-written stimulus.

## Interface
- `ADDR_W`, 20, address width
- `DATA_W`, 16, data width
- `LEN_W`, 4, burst length field width (beats = `cmd_len`+1)
- `WR_CYCLES`, 2, cycles the write strobes are held per beat (≥1)
- `RD_CYCLES`, 2, cycles the read strobes are held per beat (≥1)
- `GAP_CYCLES`, 1, all-strobes-high cycles after every beat (≥1)

Ports:
- `clk` in 1, single clock; all logic on rising edge
- `rst_n` in 1, asynchronous active-low reset
- `cmd_valid` in 1 / `cmd_ready` out 1, command handshake
- `cmd_we` in 1, 1 = write, 0 = read
- `cmd_addr` in ADDR_W, first-beat address
- `cmd_len` in LEN_W, beats−1
- `cmd_be` in 2, active-high byte enables; [0] = lower, [1] = upper
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in DATA_W, write-beat data handshake
- `rd_valid` out 1 / `rd_data` out DATA_W / `rd_last` out 1, read return; no backpressure
- `busy` out 1, high when not IDLE
- `e_chipEnable_n`, `g_outputEnable_n`, `w_writeEnable_n`, `lb_lowerByteEnable_n`, `ub_upperByteEnable_n` out 1, MRAM strobes (active low)
- `address` out ADDR_W; `dqi_datainput` out DATA_W; `dqo_dataoutput` in DATA_W

## Operation
- States: IDLE, WR_WAIT, WR_STROBE, RD_STROBE, GAP.
- IDLE: `cmd_ready`=1. On accept, latch `addr`, `len`, `we` and `be`. A `be` of 00 is coerced to 11. Go to WR_WAIT if writing, otherwise RD_STROBE. `cmd_valid` is ignored outside IDLE.
- WR_WAIT: `wr_ready`=1 and all strobes high. On `wr_valid`, register `wr_data` into `dqi_datainput` and go to WR_STROBE.
- WR_STROBE, held WR_CYCLES cycles: `e`=0, `w`=0, `g`=1, `lb`/`ub`=~be. Then GAP.
- RD_STROBE, held RD_CYCLES cycles: `e`=0, `g`=0, `w`=1, `lb`/`ub`=~be. `dqo_dataoutput` is sampled on the edge ending the last strobe cycle. `rd_valid` pulses one cycle; `rd_last` marks the final beat. Then GAP.
- GAP: all strobes high for GAP_CYCLES cycles. If beats remain, address+1 (modulo 2^ADDR_W, so 0xFFFFF wraps to 0x00000) and go to WR_WAIT or RD_STROBE. Otherwise go to IDLE.
- All MRAM outputs are registered and glitch-free. `address` and `dqi_datainput` hold from strobe start through the end of GAP.
- Reset (any time, including mid-burst): strobes=1, `address`=0, `dqi_datainput`=0, `rd_valid`=0, `rd_data`=0, `rd_last`=0, `wr_ready`=0, `busy`=0, state=IDLE. `cmd_ready`=0 while `rst_n` is low and 1 from the first cycle after release.

## Timing
- Read, command accepted at cycle T: strobes low T+1..T+RD_CYCLES; `rd_valid` at T+RD_CYCLES+1; back in IDLE at T+1+RD_CYCLES+GAP_CYCLES. With defaults: `rd_valid`@T+3, `cmd_ready`@T+4.
- Write: WR_WAIT at T+1. If `wr_valid` is high at T+1, strobes are low T+2..T+1+WR_CYCLES.
- Burst beat period: RD_CYCLES+GAP_CYCLES for reads, ≥1+WR_CYCLES+GAP_CYCLES for writes. The write period stretches while `wr_valid` is low.

## Configuration
- `MRAM_CTRL_BURST_EN` defined: `cmd_len` is honoured and bursts run as above.
- Undefined: `cmd_len` is ignored, every command is one beat, `rd_last`=`rd_valid`, and the beat counter is not built.

## Structure
- `mram_pkg`: state enum, default ADDR_W/DATA_W/LEN_W, byte-enable typedef.
- Sub-module `mram_beat_timer`: loadable down-counter producing a `done` pulse. It is shared by the strobe and gap phases.

## Test plan
- Write 0x00000 = 0x5555, `be`=11 -> `e`/`w`/`lb`/`ub` low 2 cycles, `g` high, `dqi_datainput`=0x5555 stable, then 1 gap cycle.
- Read 0x00000 afterwards -> `e`/`g` low 2 cycles, `w` high, `rd_valid`@T+3 with 0x5555 and `rd_last`=1, `cmd_ready`@T+4.
- Burst write (BURST_EN), `len`=3 at 0xFFFFE, `wr_valid` dropped 2 cycles before beat 3 -> `address` 0xFFFFE, 0xFFFFF, 0x00000, 0x00001; strobes stay high during the stall.
- Byte write `be`=01 of 0xAAAA over 0x5555, then read -> `ub` high during the write; read returns 0x55AA.
- `rst_n` low during beat 2 of a read burst -> strobes high asynchronously, `rd_valid`=0, `cmd_ready`=1 the cycle after release.
- BURST_EN undefined, read with `len`=3 -> exactly one strobe window, one `rd_valid` with `rd_last`=1.
